// File: rtl/scan_sequencer.sv
// Dwell-timed 2-bit select scanner driving a 2x4 decoder (A, E).
// Optional inter-code blanking cycle enabled by defining SCAN_BLANK_EN.
module scan_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       step,
  output logic [1:0] A,
  output logic       E,
  output logic       wrap,
  output logic       busy
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_STEP  = 2'd2;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] S_BLANK = 2'd3;
`endif

  localparam logic [15:0] LAST = 16'(DWELL - 1);

  logic [1:0]  state, nstate;
  logic [15:0] cnt;
  logic        in_dwell, boundary;

  assign in_dwell = (state == S_SCAN) || (state == S_STEP);
  assign boundary = in_dwell && (cnt == LAST);

  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: begin
        if (run)       nstate = S_SCAN;
        else if (step) nstate = S_STEP;
      end
      S_SCAN: begin
        if (boundary) begin
`ifdef SCAN_BLANK_EN
          nstate = run ? S_BLANK : S_IDLE;
`else
          nstate = run ? S_SCAN : S_IDLE;
`endif
        end
      end
      S_STEP: begin
        if (boundary) nstate = S_IDLE;
      end
`ifdef SCAN_BLANK_EN
      S_BLANK: nstate = run ? S_SCAN : S_IDLE;
`endif
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      A     <= '0;
      E     <= 1'b0;
      wrap  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= nstate;
      E     <= (nstate == S_SCAN) || (nstate == S_STEP);
      busy  <= (nstate != S_IDLE);
      wrap  <= boundary && (A == 2'd3);
      if (boundary) A <= A + 2'd1;
      if (boundary || !in_dwell) cnt <= '0;
      else                       cnt <= cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer: DWELL=4 main instance plus a DWELL=1 instance.
module tb_scan_sequencer;

`ifdef SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic run = 1'b0, step = 1'b0;
  logic run1 = 1'b0, step1 = 1'b0;
  logic [1:0] a0, a1;
  logic e0, w0, b0, e1, w1, b1;
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  scan_sequencer #(.DWELL(4)) u0 (
    .clk(clk), .rst(rst), .run(run), .step(step),
    .A(a0), .E(e0), .wrap(w0), .busy(b0)
  );

  scan_sequencer #(.DWELL(1)) u1 (
    .clk(clk), .rst(rst), .run(run1), .step(step1),
    .A(a1), .E(e1), .wrap(w1), .busy(b1)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    run = 1'b0; step = 1'b0; run1 = 1'b0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // {A,E,wrap,busy} compared as one 5-bit vector throughout
  task automatic test_reset;
    #3;
    total++;
    if ({a0, e0, w0, b0} !== 5'b00000) begin
      bad++; $display("FAIL reset_u0 got=%b exp=%b", {a0, e0, w0, b0}, 5'b00000);
    end
    total++;
    if ({a1, e1, w1, b1} !== 5'b00000) begin
      bad++; $display("FAIL reset_u1 got=%b exp=%b", {a1, e1, w1, b1}, 5'b00000);
    end
    run = 1'b1;
    tick();
    total++;
    if ({a0, e0, w0, b0} !== 5'b00000) begin
      bad++; $display("FAIL reset_held got=%b exp=%b", {a0, e0, w0, b0}, 5'b00000);
    end
    run = 1'b0;
    rst = 1'b0;
    tick();
    total++;
    if ({a0, e0, w0, b0} !== 5'b00000) begin
      bad++; $display("FAIL reset_idle got=%b exp=%b", {a0, e0, w0, b0}, 5'b00000);
    end
  endtask

  task automatic test_dwell1;
    logic [4:0] exp;
    run1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      exp = {2'(k % 4), 1'b1, (k == 4), 1'b1};
      total++;
      if ({a1, e1, w1, b1} !== exp) begin
        bad++; $display("FAIL dwell1 k=%0d got=%b exp=%b", k, {a1, e1, w1, b1}, exp);
      end
    end
    run1 = 1'b0;
    tick();
    total++;
    if ({a1, e1, w1, b1} !== 5'b10000) begin
      bad++; $display("FAIL dwell1_stop got=%b exp=%b", {a1, e1, w1, b1}, 5'b10000);
    end
  endtask

  task automatic test_scan;
    logic [4:0] exp;
    run = 1'b1;
    for (int k = 0; k < 20; k++) begin
      tick();
      exp = {2'((k / 4) % 4), 1'b1, (k == 16), 1'b1};
      total++;
      if ({a0, e0, w0, b0} !== exp) begin
        bad++; $display("FAIL scan k=%0d got=%b exp=%b", k, {a0, e0, w0, b0}, exp);
      end
    end
  endtask

  task automatic test_stop;
    logic [4:0] exp;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (k == 1) run = 1'b0;
      exp = (k < 4) ? 5'b01101 : 5'b10000;
      total++;
      if ({a0, e0, w0, b0} !== exp) begin
        bad++; $display("FAIL stop k=%0d got=%b exp=%b", k, {a0, e0, w0, b0}, exp);
      end
    end
  endtask

  task automatic test_step;
    logic [4:0] exp;
    int n;
    do_reset();
    for (int s = 0; s < 3; s++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      n = 0;
      while (b0 === 1'b1 && n < 10) begin
        tick();
        n++;
      end
      total++;
      if (n !== 4 || a0 !== 2'(s + 1) || e0 !== 1'b0) begin
        bad++; $display("FAIL step_pre s=%0d cycles=%0d A=%0d exp cycles=4 A=%0d", s, n, a0, s + 1);
      end
    end
    step = 1'b1;
    for (int k = 0; k < 7; k++) begin
      tick();
      step = (k == 1);
      exp = (k < 4) ? 5'b11101 : (k == 4) ? 5'b00010 : 5'b00000;
      total++;
      if ({a0, e0, w0, b0} !== exp) begin
        bad++; $display("FAIL step k=%0d got=%b exp=%b", k, {a0, e0, w0, b0}, exp);
      end
    end
  endtask

  task automatic test_both;
    logic [4:0] exp;
    int n;
    run = 1'b1; step = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      step = 1'b0;
      exp = (k < 4) ? 5'b00101 : {2'd1, !BLANK, 1'b0, 1'b1};
      total++;
      if ({a0, e0, w0, b0} !== exp) begin
        bad++; $display("FAIL both k=%0d got=%b exp=%b", k, {a0, e0, w0, b0}, exp);
      end
    end
    run = 1'b0;
    n = 0;
    while (b0 === 1'b1 && n < 10) begin
      tick();
      n++;
    end
    total++;
    if (b0 !== 1'b0 || a0 !== (BLANK ? 2'd1 : 2'd2)) begin
      bad++; $display("FAIL both_end busy=%b A=%0d exp busy=0 A=%0d", b0, a0, BLANK ? 1 : 2);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    do_reset();
    run = 1'b1;
    n = 0;
    do begin
      tick();
      n++;
    end while (a0 !== 2'd2 && n < 30);
    tick();
    total++;
    if ({a0, e0, w0, b0} !== 5'b10101) begin
      bad++; $display("FAIL mid_pre got=%b exp=%b", {a0, e0, w0, b0}, 5'b10101);
    end
    #1 rst = 1'b1;
    #1;
    total++;
    if ({a0, e0, w0, b0} !== 5'b00000) begin
      bad++; $display("FAIL mid_async got=%b exp=%b", {a0, e0, w0, b0}, 5'b00000);
    end
    run = 1'b0;
    #1 rst = 1'b0;
    tick();
    total++;
    if ({a0, e0, w0, b0} !== 5'b00000) begin
      bad++; $display("FAIL mid_after got=%b exp=%b", {a0, e0, w0, b0}, 5'b00000);
    end
  endtask

`ifdef SCAN_BLANK_EN
  task automatic test_blank;
    logic [4:0] exp;
    do_reset();
    run = 1'b1;
    for (int k = 0; k < 15; k++) begin
      tick();
      exp = {2'(((k + 1) / 5) % 4), (k % 5 != 4), 1'b0, 1'b1};
      total++;
      if ({a0, e0, w0, b0} !== exp) begin
        bad++; $display("FAIL blank k=%0d got=%b exp=%b", k, {a0, e0, w0, b0}, exp);
      end
    end
    run = 1'b0;
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    test_reset();
    if (!BLANK) begin
      test_dwell1();
      test_scan();
      test_stop();
    end
    test_step();
    test_both();
    test_reset_mid();
`ifdef SCAN_BLANK_EN
    test_blank();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
